// File: rtl/instr_encoder.sv
// Instruction encoder: takes decoded instruction fields, builds 32-bit MIPS
// words, buffers them in a small FIFO and streams them into instruction
// memory at ascending word addresses.
module instr_encoder #(
   parameter int Width  = 6,   // opcode / funct field width
   parameter int DEPTH  = 4,   // encoded-word FIFO entries (power of 2)
   parameter int ADDR_W = 8    // instruction-memory word-address width
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_end,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [2:0]        in_alu,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [25:0]       in_imm,
   input  logic              im_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              err,
   output logic              wrapped,
   output logic              done
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [Width-1:0] OP_RTYPE = Width'(6'b000000);
   localparam logic [Width-1:0] OP_LW    = Width'(6'b100011);
   localparam logic [Width-1:0] OP_SW    = Width'(6'b101011);
   localparam logic [Width-1:0] OP_ADDI  = Width'(6'b001000);
   localparam logic [Width-1:0] OP_BEQ   = Width'(6'b000100);
   localparam logic [Width-1:0] OP_J     = Width'(6'b000010);

   localparam logic [Width-1:0] FN_ADD   = Width'(6'b100000);
   localparam logic [Width-1:0] FN_SUB   = Width'(6'b100010);
   localparam logic [Width-1:0] FN_SLT   = Width'(6'b101010);
   localparam logic [Width-1:0] FN_MUL   = Width'(6'b011100);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t             state_reg, state_next;
   logic [31:0]        fifo_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic               we_reg, err_reg, wrapped_reg;
   logic [ADDR_W-1:0]  im_addr_reg;
   logic [31:0]        wdata_reg;

   logic [Width-1:0]   op, funct;
   logic               legal;
   logic [31:0]        enc_word;
   logic               accept, push, pop;

   // Field-to-word encoder; flags kinds and ALU codes that have no encoding
   always_comb begin
      legal    = 1'b1;
      op       = '0;
      funct    = '0;
      enc_word = '0;
      case (in_kind)
         3'd0: op = OP_LW;
         3'd1: op = OP_SW;
         3'd2: op = OP_RTYPE;
         3'd3: op = OP_ADDI;
         3'd4: op = OP_BEQ;
         3'd5: op = OP_J;
         default: legal = 1'b0;
      endcase
      if (in_kind == 3'd2) begin
         case (in_alu)
            3'b010: funct = FN_ADD;
            3'b100: funct = FN_SUB;
            3'b110: funct = FN_SLT;
            3'b101: funct = FN_MUL;
            default: legal = 1'b0;
         endcase
         enc_word = 32'({op, in_rs, in_rt, in_rd, 5'd0, funct});
      end else if (in_kind == 3'd5) begin
         enc_word = 32'({op, in_imm});
      end else begin
         enc_word = 32'({op, in_rs, in_rt, in_imm[15:0]});
      end
   end

   // Handshake and FIFO traffic; a load_start flushes, so nothing moves that cycle
   assign in_ready = (state_reg == LOAD) && (count_reg < CNT_W'(DEPTH)) && !load_start;
   assign accept   = in_valid && in_ready;
   assign push     = accept && legal;
   assign pop      = ((state_reg == LOAD) || (state_reg == DRAIN)) &&
                     (count_reg != '0) && im_ready && !load_start;

   // Next-state logic: load_start restarts from any state and beats load_end
   always_comb begin
      state_next = state_reg;
      if (load_start) begin
         state_next = LOAD;
      end else begin
         case (state_reg)
            LOAD:    if (load_end) state_next = DRAIN;
            DRAIN:   if ((count_reg == '0) && !pop) state_next = DONE;
            default: state_next = state_reg;
         endcase
      end
   end

   // FIFO storage; written only on a legal accepted instruction
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= enc_word;
   end

   // State, FIFO pointers, address counter and registered memory write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         addr_reg    <= '0;
         we_reg      <= 1'b0;
         err_reg     <= 1'b0;
         wrapped_reg <= 1'b0;
         im_addr_reg <= '0;
         wdata_reg   <= '0;
      end else begin
         state_reg <= state_next;
         we_reg    <= pop;
         err_reg   <= accept && !legal;
         if (load_start) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            addr_reg    <= '0;
            wrapped_reg <= 1'b0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop) begin
               rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
               im_addr_reg <= addr_reg;
               wdata_reg   <= fifo_mem[rd_ptr_reg];
               addr_reg    <= addr_reg + ADDR_W'(1);
               if (&addr_reg) wrapped_reg <= 1'b1;
            end
            case ({push, pop})
               2'b10:   count_reg <= count_reg + CNT_W'(1);
               2'b01:   count_reg <= count_reg - CNT_W'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   assign im_we    = we_reg;
   assign im_addr  = im_addr_reg;
   assign im_wdata = wdata_reg;
   assign err      = err_reg;
   assign wrapped  = wrapped_reg;
   assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed instruction words.
module tb_instr_encoder;

   localparam int AW  = 8;
   localparam int DEP = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0, load_end = 1'b0, in_valid = 1'b0;
   logic [2:0]    in_kind = '0, in_alu = '0;
   logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
   logic [25:0]   in_imm = '0;
   logic          im_ready = 1'b0;
   logic          in_ready, im_we, err, wrapped, done;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;

   instr_encoder #(.Width(6), .DEPTH(DEP), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_alu(in_alu), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .im_ready(im_ready), .im_we(im_we),
      .im_addr(im_addr), .im_wdata(im_wdata), .err(err),
      .wrapped(wrapped), .done(done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding straight from the opcode/funct tables
   function automatic logic [31:0] model_enc(input int kind, input int alu, input int rs,
                                             input int rt, input int rd, input int imm,
                                             output bit ok);
      int opc;
      int fn;
      opc = 0;
      fn  = 0;
      ok  = 1'b1;
      case (kind)
         0: opc = 35;
         1: opc = 43;
         2: opc = 0;
         3: opc = 8;
         4: opc = 4;
         5: opc = 2;
         default: begin ok = 1'b0; return 32'd0; end
      endcase
      if (kind == 5) return 32'((opc << 26) + (imm & 'h3FFFFFF));
      if (kind == 2) begin
         case (alu)
            2: fn = 32;
            4: fn = 34;
            6: fn = 42;
            5: fn = 28;
            default: begin ok = 1'b0; return 32'd0; end
         endcase
         return 32'((opc << 26) + (rs << 21) + (rt << 16) + (rd << 11) + fn);
      end
      return 32'((opc << 26) + (rs << 21) + (rt << 16) + (imm & 'hFFFF));
   endfunction

   // Model: phase 0 idle, 1 load, 2 drain, 3 done; queue holds pending words
   int            m_phase = 0;
   logic [31:0]   q[$];
   int            m_cnt = 0;
   bit            m_wrapped = 0, m_we = 0, m_err = 0;
   logic [AW-1:0] m_addr = '0;
   logic [31:0]   m_wdata = '0;

   function automatic bit m_ready();
      return (m_phase == 1) && (q.size() < DEP) && !load_start;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit acc, pp, ok;
      logic [31:0] w;
      int sz;
      if (rst) begin
         m_phase = 0; q.delete(); m_cnt = 0; m_wrapped = 0;
         m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0;
      end else begin
         sz  = q.size();
         acc = in_valid && m_ready();
         pp  = (m_phase == 1 || m_phase == 2) && sz > 0 && im_ready && !load_start;
         w   = model_enc(in_kind, in_alu, in_rs, in_rt, in_rd, in_imm, ok);
         if (load_start) begin
            q.delete(); m_cnt = 0; m_wrapped = 0; m_phase = 1; m_we = 0; m_err = 0;
         end else begin
            m_we  = pp;
            m_err = acc && !ok;
            if (pp) begin
               m_wdata = q.pop_front();
               m_addr  = AW'(m_cnt % (1 << AW));
               if (m_cnt % (1 << AW) == (1 << AW) - 1) m_wrapped = 1;
               m_cnt++;
            end
            if (acc && ok) q.push_back(w);
            if (m_phase == 1 && load_end) m_phase = 2;
            else if (m_phase == 2 && sz == 0 && !pp) m_phase = 3;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", in_ready, m_ready());
         check("im_we", im_we, m_we);
         check("im_addr", im_addr, m_addr);
         check("im_wdata", im_wdata, m_wdata);
         check("err", err, m_err);
         check("wrapped", wrapped, m_wrapped);
         check("done", done, m_phase == 3);
      end
   end

   // Log of memory writes and err pulses for the directed checks
   typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
   wr_t wlog[$];
   int  errs = 0;
   always @(negedge clk) begin
      if (im_we === 1'b1) wlog.push_back('{im_addr, im_wdata});
      if (err === 1'b1) errs++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1; step(); load_start = 1'b0;
   endtask

   task automatic pulse_end();
      load_end = 1'b1; step(); load_end = 1'b0;
   endtask

   task automatic send(input int kind, input int alu, input int rs, input int rt, input int rd,
                       input int imm, input int budget, output bit acc);
      in_kind = 3'(kind); in_alu = 3'(alu); in_rs = 5'(rs); in_rt = 5'(rt);
      in_rd = 5'(rd); in_imm = 26'(imm); in_valid = 1'b1; acc = 1'b0;
      for (int i = 0; i < budget && !acc; i++) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_ok(input int kind, input int alu, input int rs, input int rt,
                          input int rd, input int imm);
      bit acc;
      send(kind, alu, rs, rt, rd, imm, 20, acc);
      check("accept", acc, 1'b1);
   endtask

   task automatic wait_writes(input int n);
      for (int i = 0; i < 40 && wlog.size() < n; i++) step();
      check("write_count", wlog.size(), n);
   endtask

   initial begin
      bit ok;
      bit acc;
      logic [31:0] w;
      #1 chk_en = 1'b1;
      repeat (2) step();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_im_we", im_we, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_im_addr", im_addr, 0);
      rst = 1'b0;
      step();

      // Pin the reference encoder with hand-computed words
      w = model_enc(3, 0, 0, 8, 0, 5, ok);          check("enc_addi", w, 32'h20080005);
      w = model_enc(2, 2, 9, 10, 8, 0, ok);         check("enc_add", w, 32'h012A4020);
      w = model_enc(0, 0, 29, 8, 0, 4, ok);         check("enc_lw", w, 32'h8FA80004);
      w = model_enc(5, 0, 0, 0, 0, 'h10, ok);       check("enc_j", w, 32'h08000010);
      w = model_enc(2, 0, 1, 1, 1, 0, ok);          check("enc_bad_alu_ok", ok, 1'b0);

      // ADDI with minimum latency
      im_ready = 1'b1;
      pulse_start();
      wlog.delete();
      send_ok(3, 0, 0, 8, 0, 5);
      check("lat_we_pre", im_we, 1'b0);
      step();
      check("lat_we", im_we, 1'b1);
      check("lat_addr", im_addr, 0);
      check("lat_data", im_wdata, 32'h20080005);

      // R-type, LW, J in sequence
      pulse_start();
      wlog.delete();
      send_ok(2, 2, 9, 10, 8, 0);
      send_ok(0, 0, 29, 8, 0, 4);
      send_ok(5, 0, 0, 0, 0, 'h10);
      wait_writes(3);
      if (wlog.size() >= 3) begin
         check("seq0_d", wlog[0].d, 32'h012A4020); check("seq0_a", wlog[0].a, 0);
         check("seq1_d", wlog[1].d, 32'h8FA80004); check("seq1_a", wlog[1].a, 1);
         check("seq2_d", wlog[2].d, 32'h08000010); check("seq2_a", wlog[2].a, 2);
      end

      // Back-pressure: FIFO fills at DEPTH, then drains in order
      im_ready = 1'b0;
      pulse_start();
      wlog.delete();
      for (int i = 0; i < 4; i++) send_ok(3, 0, 1, 2, 0, i + 1);
      check("full_in_ready", in_ready, 1'b0);
      send(3, 0, 1, 2, 0, 5, 3, acc);
      check("full_reject", acc, 1'b0);
      im_ready = 1'b1;
      repeat (8) step();
      check("full_writes", wlog.size(), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++) begin
         check("full_a", wlog[i].a, i);
         check("full_d", wlog[i].d, 32'h20220001 + i);
      end

      // Illegal instructions: err pulses, no writes, address not consumed
      pulse_start();
      wlog.delete();
      errs = 0;
      send_ok(7, 0, 0, 0, 0, 0);
      send_ok(2, 0, 1, 2, 3, 0);
      repeat (3) step();
      check("ill_errs", errs, 2);
      check("ill_nowrite", wlog.size(), 0);
      send_ok(3, 0, 0, 8, 0, 'h77);
      wait_writes(1);
      if (wlog.size() >= 1) begin
         check("ill_next_a", wlog[0].a, 0);
         check("ill_next_d", wlog[0].d, 32'h20080077);
      end

      // Drain to DONE
      im_ready = 1'b0;
      pulse_start();
      wlog.delete();
      send_ok(3, 0, 0, 8, 0, 1);
      send_ok(3, 0, 0, 8, 0, 2);
      pulse_end();
      check("drain_done0", done, 1'b0);
      im_ready = 1'b1;
      repeat (5) step();
      check("drain_writes", wlog.size(), 2);
      check("drain_done1", done, 1'b1);

      // Reset in the middle of DRAIN
      im_ready = 1'b0;
      pulse_start();
      send_ok(3, 0, 0, 8, 0, 3);
      send_ok(3, 0, 0, 8, 0, 4);
      pulse_end();
      rst = 1'b1;
      #1;
      check("rstd_we", im_we, 1'b0);
      check("rstd_addr", im_addr, 0);
      check("rstd_data", im_wdata, 0);
      check("rstd_done", done, 1'b0);
      check("rstd_ready", in_ready, 1'b0);
      step();
      rst = 1'b0;
      wlog.delete();
      im_ready = 1'b1;
      repeat (6) step();
      check("rstd_nowrite", wlog.size(), 0);
      check("rstd_idle_done", done, 1'b0);

      // Address wrap after 2^AW words
      pulse_start();
      wlog.delete();
      for (int i = 0; i < 257; i++) send_ok(3, 0, 0, 8, 0, i);
      wait_writes(257);
      if (wlog.size() >= 257) begin
         check("wrap_a255", wlog[255].a, 255);
         check("wrap_a256", wlog[256].a, 0);
         check("wrap_d256", wlog[256].d, 32'h20080100);
      end
      check("wrap_flag", wrapped, 1'b1);

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
